// File: rtl/vga_pkg.sv
// Shared VGA timing constants, phase/state encodings and quadrant helper
// for the sync generator and its axis counters.
package vga_pkg;

  localparam int VGA_H_ACTIVE = 640;
  localparam int VGA_H_FRONT  = 16;
  localparam int VGA_H_SYNC   = 96;
  localparam int VGA_H_BACK   = 48;
  localparam int VGA_V_ACTIVE = 480;
  localparam int VGA_V_FRONT  = 10;
  localparam int VGA_V_SYNC   = 2;
  localparam int VGA_V_BACK   = 33;

  localparam int VGA_H_TOTAL = VGA_H_ACTIVE + VGA_H_FRONT + VGA_H_SYNC + VGA_H_BACK;
  localparam int VGA_V_TOTAL = VGA_V_ACTIVE + VGA_V_FRONT + VGA_V_SYNC + VGA_V_BACK;

  localparam int VGA_H_SYNC_START = VGA_H_ACTIVE + VGA_H_FRONT;
  localparam int VGA_H_BACK_START = VGA_H_SYNC_START + VGA_H_SYNC;
  localparam int VGA_V_SYNC_START = VGA_V_ACTIVE + VGA_V_FRONT;
  localparam int VGA_V_BACK_START = VGA_V_SYNC_START + VGA_V_SYNC;

  localparam int   VGA_CLK_DIV     = 2;
  localparam logic VGA_SYNC_ACTIVE = 1'b0;

  typedef enum logic [1:0] {ACTIVE, FRONT, SYNC, BACK} axis_phase_t;
  typedef enum logic {IDLE, RUN} top_state_t;

  localparam logic [2:0] QUAD_NONE = 3'b000;
  localparam logic [2:0] QUAD_TL   = 3'b001;
  localparam logic [2:0] QUAD_TR   = 3'b010;
  localparam logic [2:0] QUAD_BL   = 3'b011;
  localparam logic [2:0] QUAD_BR   = 3'b100;

  // Centre row/column belong to the upper/left quadrants.
  function automatic logic [2:0] quadrant_code(input logic [9:0] px, input logic [9:0] py,
                                               input logic [9:0] cx, input logic [9:0] cy,
                                               input logic vis);
    logic [2:0] q;
    q = QUAD_NONE;
    if (vis) begin
      if (py <= cy) q = (px <= cx) ? QUAD_TL : QUAD_TR;
      else          q = (px <= cx) ? QUAD_BL : QUAD_BR;
    end
    return q;
  endfunction

endpackage

// File: rtl/vga_sync_gen_if.sv
// Video timing bundle from the sync generator to the pixel painter.
interface vga_sync_gen_if;
  logic [9:0] x;
  logic [9:0] y;
  logic       hsync;
  logic       vsync;
  logic       video_on;
  logic [2:0] seccion_actual;
  logic       line_start;
  logic       frame_start;
  logic [7:0] frame_count;

  modport master (output x, y, hsync, vsync, video_on, seccion_actual,
                  line_start, frame_start, frame_count);
  modport slave  (input  x, y, hsync, vsync, video_on, seccion_actual,
                  line_start, frame_start, frame_count);
endinterface

// File: rtl/vga_axis_counter.sv
// One timing axis: position counter with wrap flag and ACTIVE/FRONT/SYNC/BACK phase.
// Exposes next-state values so the parent can register derived outputs in step.
module vga_axis_counter
  import vga_pkg::*;
#(
  parameter int ACTIVE_LEN = VGA_H_ACTIVE,
  parameter int FRONT_LEN  = VGA_H_FRONT,
  parameter int SYNC_LEN   = VGA_H_SYNC,
  parameter int BACK_LEN   = VGA_H_BACK
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        en,
  output logic [9:0]  count,
  output logic [9:0]  count_nxt,
  output axis_phase_t phase_nxt,
  output logic        wrap
);
  localparam logic [9:0] LAST     = 10'(ACTIVE_LEN + FRONT_LEN + SYNC_LEN + BACK_LEN - 1);
  localparam logic [9:0] FRONT_AT = 10'(ACTIVE_LEN);
  localparam logic [9:0] SYNC_AT  = 10'(ACTIVE_LEN + FRONT_LEN);
  localparam logic [9:0] BACK_AT  = 10'(ACTIVE_LEN + FRONT_LEN + SYNC_LEN);

  axis_phase_t phase;

  assign wrap = (count == LAST);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= 10'd0;
      phase <= ACTIVE;
    end else begin
      count <= count_nxt;
      phase <= phase_nxt;
    end
  end

  always_comb begin
    count_nxt = count;
    phase_nxt = phase;
    if (en) begin
      count_nxt = wrap ? 10'd0 : count + 10'd1;
      case (phase)
        ACTIVE:  if (count_nxt == FRONT_AT) phase_nxt = FRONT;
        FRONT:   if (count_nxt == SYNC_AT)  phase_nxt = SYNC;
        SYNC:    if (count_nxt == BACK_AT)  phase_nxt = BACK;
        BACK:    if (wrap)                  phase_nxt = ACTIVE;
        default: phase_nxt = ACTIVE;
      endcase
    end
  end

endmodule

// File: rtl/vga_sync_gen.sv
// VGA timing generator: pixel-rate divider, IDLE/RUN start-up, H/V axis counters,
// registered sync/visibility/quadrant outputs, line/frame pulses and frame counter.
module vga_sync_gen
  import vga_pkg::*;
#(
  parameter int   H_ACTIVE    = VGA_H_ACTIVE,
  parameter int   H_FRONT     = VGA_H_FRONT,
  parameter int   H_SYNC      = VGA_H_SYNC,
  parameter int   H_BACK      = VGA_H_BACK,
  parameter int   V_ACTIVE    = VGA_V_ACTIVE,
  parameter int   V_FRONT     = VGA_V_FRONT,
  parameter int   V_SYNC      = VGA_V_SYNC,
  parameter int   V_BACK      = VGA_V_BACK,
  parameter int   CLK_DIV     = VGA_CLK_DIV,
  parameter logic SYNC_ACTIVE = VGA_SYNC_ACTIVE
) (
  input logic            clk,
  input logic            reset,
  vga_sync_gen_if.master vga
);
  localparam logic [3:0] DIV_LAST = 4'(CLK_DIV - 1);
  localparam logic [9:0] H_MID    = 10'(H_ACTIVE / 2);
  localparam logic [9:0] V_MID    = 10'(V_ACTIVE / 2);

  logic [3:0]  div;
  logic        pix_tick, enter_run, run_tick, frame_wrap;
  top_state_t  state, state_nxt;
  logic [9:0]  h_count, h_count_nxt, v_count, v_count_nxt;
  axis_phase_t h_phase_nxt, v_phase_nxt;
  logic        h_wrap, v_wrap, vis_nxt;

  assign pix_tick = (div == DIV_LAST);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) div <= 4'd0;
    else       div <= pix_tick ? 4'd0 : div + 4'd1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (state == IDLE && pix_tick) state_nxt = RUN;
  end

  // The IDLE->RUN tick presents (0,0) without advancing the counters.
  assign enter_run  = pix_tick && (state == IDLE);
  assign run_tick   = pix_tick && (state == RUN);
  assign frame_wrap = run_tick && h_wrap && v_wrap;

  vga_axis_counter #(
    .ACTIVE_LEN(H_ACTIVE), .FRONT_LEN(H_FRONT), .SYNC_LEN(H_SYNC), .BACK_LEN(H_BACK)
  ) u_h (
    .clk(clk), .reset(reset), .en(run_tick),
    .count(h_count), .count_nxt(h_count_nxt), .phase_nxt(h_phase_nxt), .wrap(h_wrap)
  );

  vga_axis_counter #(
    .ACTIVE_LEN(V_ACTIVE), .FRONT_LEN(V_FRONT), .SYNC_LEN(V_SYNC), .BACK_LEN(V_BACK)
  ) u_v (
    .clk(clk), .reset(reset), .en(run_tick && h_wrap),
    .count(v_count), .count_nxt(v_count_nxt), .phase_nxt(v_phase_nxt), .wrap(v_wrap)
  );

  assign vis_nxt = (h_phase_nxt == ACTIVE) && (v_phase_nxt == ACTIVE);
  assign vga.x   = h_count;
  assign vga.y   = v_count;

  // Derived outputs are built from the position being loaded so they align with x/y.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vga.hsync          <= ~SYNC_ACTIVE;
      vga.vsync          <= ~SYNC_ACTIVE;
      vga.video_on       <= 1'b0;
      vga.seccion_actual <= QUAD_NONE;
      vga.line_start     <= 1'b0;
      vga.frame_start    <= 1'b0;
      vga.frame_count    <= 8'd0;
    end else begin
      vga.line_start  <= enter_run || (run_tick && h_wrap);
      vga.frame_start <= enter_run || frame_wrap;
      if (pix_tick) begin
        vga.hsync          <= (h_phase_nxt == SYNC) ? SYNC_ACTIVE : ~SYNC_ACTIVE;
        vga.vsync          <= (v_phase_nxt == SYNC) ? SYNC_ACTIVE : ~SYNC_ACTIVE;
        vga.video_on       <= vis_nxt;
        vga.seccion_actual <= quadrant_code(h_count_nxt, v_count_nxt, H_MID, V_MID, vis_nxt);
      end
      if (frame_wrap) vga.frame_count <= vga.frame_count + 8'd1;
    end
  end

endmodule

// File: tb/tb_vga_sync_gen.sv
// Directed bench: full 640x480 timing at CLK_DIV=2 for start-up and one line sweep,
// plus a reduced 8x6 geometry at CLK_DIV=1 for quadrants, frame wrap and mid-frame reset.
module tb_vga_sync_gen;
  logic clk = 1'b0;
  logic rst_a = 1'b1;
  logic rst_s = 1'b1;
  int checks = 0;
  int failures = 0;

  localparam int SH_TOT = 14;
  localparam int SF_TOT = 140;
  localparam int S_END  = 257 * SF_TOT + 61;

  always #5 clk = ~clk;

  vga_sync_gen_if ifa();
  vga_sync_gen_if ifs();

  vga_sync_gen #(.CLK_DIV(2)) dut_a (.clk(clk), .reset(rst_a), .vga(ifa));

  vga_sync_gen #(
    .H_ACTIVE(8), .H_FRONT(2), .H_SYNC(2), .H_BACK(2),
    .V_ACTIVE(6), .V_FRONT(1), .V_SYNC(2), .V_BACK(1),
    .CLK_DIV(1)
  ) dut_s (.clk(clk), .reset(rst_s), .vga(ifs));

  task automatic test_reset();
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({ifa.x, ifa.y} !== 20'd0) begin
      failures++; $display("FAIL reset_a_pos got=%h exp=%h", {ifa.x, ifa.y}, 20'd0);
    end
    checks++;
    if ({ifa.hsync, ifa.vsync} !== 2'b11) begin
      failures++; $display("FAIL reset_a_sync got=%b exp=11", {ifa.hsync, ifa.vsync});
    end
    checks++;
    if ({ifa.video_on, ifa.seccion_actual} !== 4'b0000) begin
      failures++; $display("FAIL reset_a_video got=%b exp=0000", {ifa.video_on, ifa.seccion_actual});
    end
    checks++;
    if ({ifa.line_start, ifa.frame_start} !== 2'b00) begin
      failures++; $display("FAIL reset_a_pulses got=%b exp=00", {ifa.line_start, ifa.frame_start});
    end
    checks++;
    if (ifa.frame_count !== 8'd0) begin
      failures++; $display("FAIL reset_a_fc got=%0d exp=0", ifa.frame_count);
    end
    checks++;
    if ({ifs.x, ifs.y, ifs.hsync, ifs.vsync, ifs.video_on, ifs.seccion_actual,
         ifs.line_start, ifs.frame_start, ifs.frame_count} !== {20'd0, 2'b11, 4'b0000, 2'b00, 8'd0}) begin
      failures++;
      $display("FAIL reset_s_all got=%h exp=%h",
               {ifs.x, ifs.y, ifs.hsync, ifs.vsync, ifs.video_on, ifs.seccion_actual,
                ifs.line_start, ifs.frame_start, ifs.frame_count},
               {20'd0, 2'b11, 4'b0000, 2'b00, 8'd0});
    end
  endtask

  task automatic test_release_div2();
    @(negedge clk) rst_a = 1'b0;
    @(posedge clk); #1;
    checks++;
    if ({ifa.x, ifa.y, ifa.video_on, ifa.line_start, ifa.frame_start} !== 23'd0) begin
      failures++;
      $display("FAIL release_edge1 got=%h exp=0", {ifa.x, ifa.y, ifa.video_on, ifa.line_start, ifa.frame_start});
    end
    @(posedge clk); #1;
    checks++;
    if ({ifa.x, ifa.y} !== 20'd0) begin
      failures++; $display("FAIL release_edge2_pos got=%h exp=0", {ifa.x, ifa.y});
    end
    checks++;
    if ({ifa.video_on, ifa.seccion_actual} !== 4'b1001) begin
      failures++; $display("FAIL release_edge2_video got=%b exp=1001", {ifa.video_on, ifa.seccion_actual});
    end
    checks++;
    if ({ifa.line_start, ifa.frame_start} !== 2'b11) begin
      failures++; $display("FAIL release_edge2_pulses got=%b exp=11", {ifa.line_start, ifa.frame_start});
    end
    checks++;
    if ({ifa.hsync, ifa.vsync, ifa.frame_count} !== {2'b11, 8'd0}) begin
      failures++; $display("FAIL release_edge2_sync got=%h exp=%h", {ifa.hsync, ifa.vsync, ifa.frame_count}, {2'b11, 8'd0});
    end
  endtask

  task automatic test_h_sweep();
    logic [9:0] exv, eyv, pxv;
    logic       e_hs, e_vis;
    logic [2:0] e_q;
    for (int p = 1; p <= 802; p++) begin
      pxv = 10'((p - 1) % 800);
      @(posedge clk); #1;
      checks++;
      if ({ifa.x, ifa.line_start, ifa.frame_start} !== {pxv, 2'b00}) begin
        failures++;
        $display("FAIL sweep_hold p=%0d got=%h exp=%h", p, {ifa.x, ifa.line_start, ifa.frame_start}, {pxv, 2'b00});
      end
      exv = 10'(p % 800);
      eyv = 10'(p / 800);
      e_hs = (exv >= 10'd656 && exv <= 10'd751) ? 1'b0 : 1'b1;
      e_vis = (exv < 10'd640) && (eyv < 10'd480);
      e_q = !e_vis ? 3'b000 : (exv <= 10'd320) ? 3'b001 : 3'b010;
      @(posedge clk); #1;
      checks++;
      if ({ifa.x, ifa.y} !== {exv, eyv}) begin
        failures++; $display("FAIL sweep_pos p=%0d got=%0d,%0d exp=%0d,%0d", p, ifa.x, ifa.y, exv, eyv);
      end
      checks++;
      if ({ifa.hsync, ifa.vsync} !== {e_hs, 1'b1}) begin
        failures++; $display("FAIL sweep_sync p=%0d got=%b exp=%b", p, {ifa.hsync, ifa.vsync}, {e_hs, 1'b1});
      end
      checks++;
      if ({ifa.video_on, ifa.seccion_actual} !== {e_vis, e_q}) begin
        failures++; $display("FAIL sweep_video p=%0d got=%b exp=%b", p, {ifa.video_on, ifa.seccion_actual}, {e_vis, e_q});
      end
      checks++;
      if ({ifa.line_start, ifa.frame_start, ifa.frame_count} !== {(exv == 10'd0), 1'b0, 8'd0}) begin
        failures++;
        $display("FAIL sweep_pulses p=%0d got=%h exp=%h", p, {ifa.line_start, ifa.frame_start, ifa.frame_count},
                 {(exv == 10'd0), 1'b0, 8'd0});
      end
    end
  endtask

  task automatic test_small_frames();
    int pos, ex, ey, last_fs, last_ls, n_fs, n_ls;
    logic       e_hs, e_vs, e_vis;
    logic [2:0] e_q;
    logic [7:0] e_fc;
    last_fs = -1; last_ls = -1; n_fs = 0; n_ls = 0;
    @(negedge clk) rst_s = 1'b0;
    for (int t = 0; t <= S_END; t++) begin
      @(posedge clk); #1;
      pos = t % SF_TOT;
      ex = pos % SH_TOT;
      ey = pos / SH_TOT;
      e_fc = 8'((t / SF_TOT) % 256);
      e_hs = (ex == 10 || ex == 11) ? 1'b0 : 1'b1;
      e_vs = (ey == 7 || ey == 8) ? 1'b0 : 1'b1;
      e_vis = (ex < 8) && (ey < 6);
      if (!e_vis)                e_q = 3'b000;
      else if (ex <= 4 && ey <= 3) e_q = 3'b001;
      else if (ey <= 3)          e_q = 3'b010;
      else if (ex <= 4)          e_q = 3'b011;
      else                       e_q = 3'b100;
      checks++;
      if ({ifs.x, ifs.y} !== {10'(ex), 10'(ey)}) begin
        failures++; $display("FAIL small_pos t=%0d got=%0d,%0d exp=%0d,%0d", t, ifs.x, ifs.y, ex, ey);
      end
      checks++;
      if ({ifs.hsync, ifs.vsync} !== {e_hs, e_vs}) begin
        failures++; $display("FAIL small_sync t=%0d got=%b exp=%b", t, {ifs.hsync, ifs.vsync}, {e_hs, e_vs});
      end
      checks++;
      if ({ifs.video_on, ifs.seccion_actual} !== {e_vis, e_q}) begin
        failures++; $display("FAIL small_quad t=%0d got=%b exp=%b", t, {ifs.video_on, ifs.seccion_actual}, {e_vis, e_q});
      end
      checks++;
      if ({ifs.line_start, ifs.frame_start} !== {(ex == 0), (pos == 0)}) begin
        failures++;
        $display("FAIL small_pulses t=%0d got=%b exp=%b", t, {ifs.line_start, ifs.frame_start}, {(ex == 0), (pos == 0)});
      end
      checks++;
      if (ifs.frame_count !== e_fc) begin
        failures++; $display("FAIL small_fc t=%0d got=%0d exp=%0d", t, ifs.frame_count, e_fc);
      end
      if (ifs.frame_start === 1'b1) begin
        n_fs++;
        if (last_fs >= 0) begin
          checks++;
          if (t - last_fs != SF_TOT) begin
            failures++; $display("FAIL frame_period t=%0d got=%0d exp=%0d", t, t - last_fs, SF_TOT);
          end
        end
        last_fs = t;
      end
      if (ifs.line_start === 1'b1) begin
        n_ls++;
        if (last_ls >= 0) begin
          checks++;
          if (t - last_ls != SH_TOT) begin
            failures++; $display("FAIL line_period t=%0d got=%0d exp=%0d", t, t - last_ls, SH_TOT);
          end
        end
        last_ls = t;
      end
    end
    checks++;
    if (n_fs != S_END / SF_TOT + 1) begin
      failures++; $display("FAIL frame_pulse_count got=%0d exp=%0d", n_fs, S_END / SF_TOT + 1);
    end
    checks++;
    if (n_ls != S_END / SH_TOT + 1) begin
      failures++; $display("FAIL line_pulse_count got=%0d exp=%0d", n_ls, S_END / SH_TOT + 1);
    end
  endtask

  task automatic test_mid_frame_reset();
    #2 rst_s = 1'b1;
    #1;
    checks++;
    if ({ifs.x, ifs.y} !== 20'd0) begin
      failures++; $display("FAIL midreset_pos got=%0d,%0d exp=0,0", ifs.x, ifs.y);
    end
    checks++;
    if ({ifs.hsync, ifs.vsync, ifs.video_on, ifs.seccion_actual, ifs.line_start, ifs.frame_start} !== 8'b1100_0000) begin
      failures++;
      $display("FAIL midreset_ctl got=%b exp=11000000",
               {ifs.hsync, ifs.vsync, ifs.video_on, ifs.seccion_actual, ifs.line_start, ifs.frame_start});
    end
    checks++;
    if (ifs.frame_count !== 8'd0) begin
      failures++; $display("FAIL midreset_fc got=%0d exp=0", ifs.frame_count);
    end
    repeat (2) @(posedge clk);
    @(negedge clk) rst_s = 1'b0;
    @(posedge clk); #1;
    checks++;
    if ({ifs.x, ifs.y, ifs.video_on, ifs.seccion_actual, ifs.line_start, ifs.frame_start, ifs.frame_count}
        !== {20'd0, 1'b1, 3'b001, 2'b11, 8'd0}) begin
      failures++;
      $display("FAIL restart_entry got=%h exp=%h",
               {ifs.x, ifs.y, ifs.video_on, ifs.seccion_actual, ifs.line_start, ifs.frame_start, ifs.frame_count},
               {20'd0, 1'b1, 3'b001, 2'b11, 8'd0});
    end
    @(posedge clk); #1;
    checks++;
    if ({ifs.x, ifs.y, ifs.line_start, ifs.frame_start, ifs.frame_count} !== {10'd1, 10'd0, 2'b00, 8'd0}) begin
      failures++;
      $display("FAIL restart_next got=%h exp=%h",
               {ifs.x, ifs.y, ifs.line_start, ifs.frame_start, ifs.frame_count}, {10'd1, 10'd0, 2'b00, 8'd0});
    end
  endtask

  initial begin
    test_reset();
    test_release_div2();
    test_h_sweep();
    test_small_frames();
    test_mid_frame_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
